gate_sweep_sequencer: RTL and testbench

- Self-test controller for the two-input, seven-output logic-gate datapath: y[0]=AND, y[1]=OR, y[2]=NOT a, y[3]=NAND, y[4]=NOR, y[5]=XOR, y[6]=XNOR.
- On start, walks the gate inputs through all four (a,b) combinations in order 00, 01, 10, 11.
- After each combination, waits a programmable settle time, then samples y and compares it against the built-in truth table.
- Reports a per-combination fail mask and an overall pass flag. Sits beside the gate block as its sequencer in the gates test harness and in the BIST wrapper.

---
 rtl/gate_sweep_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_gate_sweep_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_sequencer.sv
// Self-test sequencer that sweeps a two-input, seven-output gate block through
// all (a,b) combinations and checks each sample. Define GATE_SWEEP_ERRCNT_EN to add err_count.
module gate_sweep_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       sample_valid,
    output logic [1:0] sample_idx,
    output logic [6:0] sample_y,
    output logic       done,
    output logic       pass,
`ifdef GATE_SWEEP_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

    // Golden response of the gate block, bits 6..0 = XNOR,XOR,NOR,NAND,NOT a,OR,AND.
    function automatic logic [6:0] expected_y(input logic [1:0] idx);
        logic [6:0] exp_v;
        case (idx)
            2'd0:    exp_v = 7'h5C;
            2'd1:    exp_v = 7'h2E;
            2'd2:    exp_v = 7'h2A;
            2'd3:    exp_v = 7'h43;
            default: exp_v = 7'h00;
        endcase
        return exp_v;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d, b_q, b_d;
    logic       busy_q, busy_d;
    logic       sample_valid_q, sample_valid_d;
    logic [1:0] sample_idx_q, sample_idx_d;
    logic [6:0] sample_y_q, sample_y_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       mismatch_s;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;
`endif

    // Case inequality so that X/Z on y_in yields a definite mismatch.
    assign mismatch_s = (y_in !== expected_y(idx_q));

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        b_d            = b_q;
        busy_d         = busy_q;
        sample_valid_d = 1'b0;
        sample_idx_d   = sample_idx_q;
        sample_y_d     = sample_y_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        fail_mask_d    = fail_mask_q;
`ifdef GATE_SWEEP_ERRCNT_EN
        err_count_d    = err_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d       = 2'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    fail_mask_d = 4'd0;
                    pass_d      = 1'b0;
                    cnt_d       = CNT_RELOAD;
                    busy_d      = 1'b1;
                    state_d     = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                fail_mask_d[idx_q] = mismatch_s;
                sample_valid_d     = 1'b1;
                sample_idx_d       = idx_q;
                sample_y_d         = y_in;
`ifdef GATE_SWEEP_ERRCNT_EN
                if (mismatch_s && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end else begin
                    err_count_d = err_count_q;
                end
`endif
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    idx_d        = idx_q + 2'd1;
                    {a_d, b_d}   = idx_q + 2'd1;
                    cnt_d        = CNT_RELOAD;
                    state_d      = S_SETTLE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = ~|fail_mask_q;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= 2'd0;
            cnt_q          <= 4'd0;
            a_q            <= 1'b0;
            b_q            <= 1'b0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= 2'd0;
            sample_y_q     <= 7'd0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_mask_q    <= 4'd0;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_count_q    <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            sample_y_q     <= sample_y_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_mask_q    <= fail_mask_d;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_count_q    <= err_count_d;
`endif
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign sample_y     = sample_y_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_mask    = fail_mask_q;
`ifdef GATE_SWEEP_ERRCNT_EN
    assign err_count    = err_count_q;
`endif

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: two instances (settle 1 and settle 3) with
// behavioural gate models and a scoreboard of expected samples.
module tb_gate_sweep_sequencer;

    typedef struct packed {
        logic [1:0] idx;
        logic [6:0] y;
    } sample_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    int         mode1 = 0;
    logic [6:0] y1, y3;
    logic       a1, b1, busy1, sv1, done1, pass1;
    logic [1:0] sidx1;
    logic [6:0] sy1;
    logic [3:0] fm1;
    logic       a3, b3, busy3, sv3, done3, pass3;
    logic [1:0] sidx3;
    logic [6:0] sy3;
    logic [3:0] fm3;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [7:0] err1, err3;
`endif
    logic [1:0] ab_d1 = 2'b00;
    logic [1:0] ab_d2 = 2'b00;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    sample_t q1[$];
    sample_t q3[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gate_sweep_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .sample_valid(sv1),
        .sample_idx(sidx1), .sample_y(sy1), .done(done1), .pass(pass1),
`ifdef GATE_SWEEP_ERRCNT_EN
        .err_count(err1),
`endif
        .fail_mask(fm1)
    );

    gate_sweep_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .y_in(y3),
        .a_out(a3), .b_out(b3), .busy(busy3), .sample_valid(sv3),
        .sample_idx(sidx3), .sample_y(sy3), .done(done3), .pass(pass3),
`ifdef GATE_SWEEP_ERRCNT_EN
        .err_count(err3),
`endif
        .fail_mask(fm3)
    );

    // Behavioural gates: {XNOR, XOR, NOR, NAND, NOT a, OR, AND}
    function automatic logic [6:0] gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    // mode 0 golden, 1 XOR stuck at 0, 2 all-X for combination 01
    function automatic logic [6:0] model_y(input int mode, input logic a, input logic b);
        logic [6:0] g;
        g = gates(a, b);
        if (mode == 1) g[5] = 1'b0;
        if (mode == 2 && a == 1'b0 && b == 1'b1) g = 7'bxxxxxxx;
        return g;
    endfunction

    always_comb y1 = model_y(mode1, a1, b1);

    always @(posedge clk) begin
        ab_d1 <= {a3, b3};
        ab_d2 <= ab_d1;
    end
    always_comb y3 = gates(ab_d2[1], ab_d2[0]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int which, input int mode);
        sample_t s;
        for (int k = 0; k < 4; k++) begin
            s.idx = 2'(k);
            s.y   = model_y(mode, s.idx[1], s.idx[0]);
            if (which == 1) q1.push_back(s);
            else q3.push_back(s);
        end
    endtask

    task automatic wait_done(input int which, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (((which == 1) ? done1 : done3) === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard: compare each sample strobe against the queued expectation.
    always @(negedge clk) begin
        sample_t e;
        if (sv1 === 1'b1) begin
            if (q1.size() == 0) check("dut1_unexpected_sample", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("dut1_sample_idx", 32'(sidx1), 32'(e.idx));
                check("dut1_sample_y", 32'(sy1), 32'(e.y));
            end
        end
        if (sv3 === 1'b1) begin
            if (q3.size() == 0) check("dut3_unexpected_sample", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                check("dut3_sample_idx", 32'(sidx3), 32'(e.idx));
                check("dut3_sample_y", 32'(sy3), 32'(e.y));
            end
        end
    end

    initial begin
        int acc;
        int at;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_fail_mask", 32'(fm1), 32'd0);
        check("rst_ab", 32'({a1, b1}), 32'd0);
        check("rst_sample_valid", 32'(sv1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Golden sweep, settle 1
        push(1, 0);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; acc = cyc; start1 = 1'b0;
        check("golden_busy", 32'(busy1), 32'd1);
        wait_done(1, at);
        check("golden_latency", 32'(at - acc), 32'd9);
        check("golden_pass", 32'(pass1), 32'd1);
        check("golden_fail_mask", 32'(fm1), 32'd0);
        check("golden_busy_off", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        check("golden_done_pulse", 32'(done1), 32'd0);

        // XOR stuck at 0
        mode1 = 1;
        push(1, 1);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; acc = cyc; start1 = 1'b0;
        wait_done(1, at);
        check("xor_latency", 32'(at - acc), 32'd9);
        check("xor_fail_mask", 32'(fm1), 32'h6);
        check("xor_pass", 32'(pass1), 32'd0);
`ifdef GATE_SWEEP_ERRCNT_EN
        check("xor_err_count", 32'(err1), 32'd2);
`endif
        mode1 = 0;

        // Settle 3 with 2-cycle delayed gate model
        push(3, 0);
        @(negedge clk); start3 = 1'b1;
        @(posedge clk); #1; acc = cyc; start3 = 1'b0;
        wait_done(3, at);
        check("delay_latency", 32'(at - acc), 32'd17);
        check("delay_pass", 32'(pass3), 32'd1);
        check("delay_fail_mask", 32'(fm3), 32'd0);

        // Start re-pulsed while busy, then held through DONE
        mode1 = 1;
        push(1, 1);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; acc = cyc; start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        check("repulse_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1; start1 = 1'b1;
        wait_done(1, at);
        check("repulse_latency", 32'(at - acc), 32'd9);
        check("repulse_fail_mask", 32'(fm1), 32'h6);
        mode1 = 0;
        push(1, 0);
        @(posedge clk); #1; acc = cyc;
        check("b2b_busy", 32'(busy1), 32'd1);
        check("b2b_fail_mask_cleared", 32'(fm1), 32'd0);
        check("b2b_pass_cleared", 32'(pass1), 32'd0);
        start1 = 1'b0;
        wait_done(1, at);
        check("b2b_latency", 32'(at - acc), 32'd9);
        check("b2b_pass", 32'(pass1), 32'd1);

        // Reset during the idx-2 settle
        push(1, 0);
        void'(q1.pop_back());
        void'(q1.pop_back());
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("mid_ab_before", 32'({a1, b1}), 32'h2);
        rst = 1'b1;
        #1;
        check("mid_rst_ab", 32'({a1, b1}), 32'd0);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        check("mid_rst_fail_mask", 32'(fm1), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_done", 32'(done1), 32'd0);
        end
        check("mid_rst_queue_empty", 32'(q1.size()), 32'd0);
        push(1, 0);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; acc = cyc; start1 = 1'b0;
        wait_done(1, at);
        check("fresh_latency", 32'(at - acc), 32'd9);
        check("fresh_pass", 32'(pass1), 32'd1);

        // X on y_in during idx 1
        mode1 = 2;
        push(1, 2);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; acc = cyc; start1 = 1'b0;
        wait_done(1, at);
        check("x_latency", 32'(at - acc), 32'd9);
        check("x_fail_mask", 32'(fm1), 32'h2);
        check("x_pass", 32'(pass1), 32'd0);
`ifdef GATE_SWEEP_ERRCNT_EN
        check("x_err_count", 32'(err1), 32'd1);
        check("dut3_err_count", 32'(err3), 32'd0);
`endif
        mode1 = 0;

        repeat (3) @(posedge clk);
        #1;
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
